// File: rtl/instr_stream_loader_pkg.sv
// +----------------------------------------------------------------------+
// | instr_enc_pkg : op select codes, MIPS opcodes and loader state codes |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package instr_enc_pkg;

  localparam logic [2:0] OP_RTYPE   = 3'd0;
  localparam logic [2:0] OP_ADDI    = 3'd1;
  localparam logic [2:0] OP_BEQ     = 3'd2;
  localparam logic [2:0] OP_BNE     = 3'd3;
  localparam logic [2:0] OP_LW      = 3'd4;
  localparam logic [2:0] OP_SW      = 3'd5;
  localparam logic [2:0] OP_JAL     = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  // Opcode values shared with the core's main decoder.
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/instr_stream_loader_if.sv
// +----------------------------------------------------------------------+
// | instr_stream_loader_if : host beat handshake plus imem write port    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface instr_stream_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [25:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/instr_stream_loader_encoder.sv
// +----------------------------------------------------------------------+
// | instr_field_encoder : packs symbolic fields into a 32-bit MIPS word  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module instr_field_encoder
  import instr_enc_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = 32'd0;
    legal = 1'b1;
    case (op)
      OP_RTYPE: word = {OPC_RTYPE, rs, rt, rd, shamt, funct};
      OP_ADDI:  word = {OPC_ADDI, rs, rt, imm[15:0]};
      OP_BEQ:   word = {OPC_BEQ, rs, rt, imm[15:0]};
      OP_BNE:   word = {OPC_BNE, rs, rt, imm[15:0]};
      OP_LW:    word = {OPC_LW, rs, rt, imm[15:0]};
      OP_SW:    word = {OPC_SW, rs, rt, imm[15:0]};
      OP_JAL:   word = {OPC_JAL, imm};
      default:  legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_stream_loader.sv
// +----------------------------------------------------------------------+
// | instr_stream_loader : streams encoded instructions into imem         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module instr_stream_loader
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  instr_stream_loader_if.slave bus,
  output logic [ADDR_W:0]      count,
  output logic                 busy,
  output logic                 done,
  output logic                 err_overflow,
  output logic                 err_illegal
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept;
  logic        write_en;
  logic        at_end;

  instr_field_encoder u_encoder (
    .op    (bus.in_op),
    .rs    (bus.in_rs),
    .rt    (bus.in_rt),
    .rd    (bus.in_rd),
    .shamt (bus.in_shamt),
    .funct (bus.in_funct),
    .imm   (bus.in_imm),
    .word  (enc_word),
    .legal (enc_legal)
  );

  assign accept   = bus.in_valid & bus.in_ready;
  assign write_en = accept & enc_legal;
  assign at_end   = (count[ADDR_W-1:0] == {ADDR_W{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_LOAD;
    end else if (state == ST_LOAD && accept) begin
      if (!enc_legal)       state_nxt = ST_ERR;
      else if (bus.in_last) state_nxt = ST_DONE;
      else if (at_end)      state_nxt = ST_ERR;
    end
  end

  always_comb begin
    bus.in_ready = (state == ST_LOAD) & ~start;
    busy         = (state == ST_LOAD);
  end

  // Write port is registered: a beat accepted in one cycle is written in the next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
      count          <= '0;
      done           <= 1'b0;
      err_overflow   <= 1'b0;
      err_illegal    <= 1'b0;
    end else begin
      bus.imem_we <= write_en;
      if (write_en) begin
        bus.imem_addr  <= count[ADDR_W-1:0];
        bus.imem_wdata <= enc_word;
      end
      if (start) begin
        count        <= '0;
        done         <= 1'b0;
        err_overflow <= 1'b0;
        err_illegal  <= 1'b0;
      end else begin
        if (write_en)                           count        <= count + (ADDR_W+1)'(1);
        if (write_en && bus.in_last)            done         <= 1'b1;
        if (write_en && !bus.in_last && at_end) err_overflow <= 1'b1;
        if (accept && !enc_legal)               err_illegal  <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_stream_loader.sv
// Directed + randomized bench for instr_stream_loader against a beat-level model.
// Instance a uses ADDR_W=6, instance b uses ADDR_W=2 for the overflow case.
`default_nettype none

module tb_instr_stream_loader;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [25:0] imm;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [6:0] count_a;
  logic [2:0] count_b;
  logic busy_a, done_a, ovf_a, ill_a;
  logic busy_b, done_b, ovf_b, ill_b;

  int errors = 0;
  int checks = 0;

  // model: one entry per instance
  bit m_load [2];
  int m_cnt  [2];
  bit m_done [2];
  bit m_ovf  [2];
  bit m_ill  [2];
  int depth  [2] = '{64, 4};

  instr_stream_loader_if #(.ADDR_W(6)) bus_a ();
  instr_stream_loader_if #(.ADDR_W(2)) bus_b ();

  instr_stream_loader #(.ADDR_W(6)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a),
    .count(count_a), .busy(busy_a), .done(done_a),
    .err_overflow(ovf_a), .err_illegal(ill_a)
  );

  instr_stream_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b),
    .count(count_b), .busy(busy_b), .done(done_b),
    .err_overflow(ovf_b), .err_illegal(ill_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(beat_t b);
    case (b.op)
      3'd0: return {6'b000000, b.rs, b.rt, b.rd, b.sh, b.fn};
      3'd1: return {6'b001000, b.rs, b.rt, b.imm[15:0]};
      3'd2: return {6'b000100, b.rs, b.rt, b.imm[15:0]};
      3'd3: return {6'b000101, b.rs, b.rt, b.imm[15:0]};
      3'd4: return {6'b100011, b.rs, b.rt, b.imm[15:0]};
      3'd5: return {6'b101011, b.rs, b.rt, b.imm[15:0]};
      3'd6: return {6'b000011, b.imm};
      default: return 32'd0;
    endcase
  endfunction

  function automatic beat_t mk(logic [2:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                               logic [5:0] fn, logic [25:0] imm, logic last);
    beat_t b;
    b.op = op; b.rs = rs; b.rt = rt; b.rd = rd; b.sh = 5'd0; b.fn = fn; b.imm = imm; b.last = last;
    return b;
  endfunction

  function automatic beat_t rand_beat(logic last);
    beat_t b;
    b.op = 3'($urandom_range(0, 6));
    b.rs = 5'($urandom); b.rt = 5'($urandom); b.rd = 5'($urandom); b.sh = 5'($urandom);
    b.fn = 6'($urandom); b.imm = 26'($urandom); b.last = last;
    return b;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_load[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_ill[i] = 0;
    end
  endtask

  task automatic drive(beat_t b);
    bus_a.in_op = b.op; bus_a.in_rs = b.rs; bus_a.in_rt = b.rt; bus_a.in_rd = b.rd;
    bus_a.in_shamt = b.sh; bus_a.in_funct = b.fn; bus_a.in_imm = b.imm; bus_a.in_last = b.last;
    bus_b.in_op = b.op; bus_b.in_rs = b.rs; bus_b.in_rt = b.rt; bus_b.in_rd = b.rd;
    bus_b.in_shamt = b.sh; bus_b.in_funct = b.fn; bus_b.in_imm = b.imm; bus_b.in_last = b.last;
  endtask

  task automatic check_status(int sel);
    chk("count", sel ? 32'(count_b) : 32'(count_a), 32'(m_cnt[sel]));
    chk("busy",  sel ? 32'(busy_b)  : 32'(busy_a),  32'(m_load[sel]));
    chk("done",  sel ? 32'(done_b)  : 32'(done_a),  32'(m_done[sel]));
    chk("err_overflow", sel ? 32'(ovf_b) : 32'(ovf_a), 32'(m_ovf[sel]));
    chk("err_illegal",  sel ? 32'(ill_b) : 32'(ill_a), 32'(m_ill[sel]));
  endtask

  // One clock cycle on instance sel: drive at negedge, check ready, then check write + status.
  task automatic step(int sel, bit st, bit vld, beat_t b);
    bit acc, wr;
    logic [31:0] exp_data;
    int exp_addr;
    @(negedge clk);
    drive(b);
    if (sel == 0) begin start_a = st; bus_a.in_valid = vld; end
    else          begin start_b = st; bus_b.in_valid = vld; end
    #1;
    chk("in_ready", sel ? 32'(bus_b.in_ready) : 32'(bus_a.in_ready), 32'(m_load[sel] && !st));
    acc      = vld && m_load[sel] && !st;
    wr       = acc && (b.op != 3'd7);
    exp_data = enc(b);
    exp_addr = m_cnt[sel] % depth[sel];
    if (st) begin
      m_load[sel] = 1; m_cnt[sel] = 0; m_done[sel] = 0; m_ovf[sel] = 0; m_ill[sel] = 0;
    end else if (acc) begin
      if (b.op == 3'd7) begin
        m_ill[sel] = 1; m_load[sel] = 0;
      end else begin
        m_cnt[sel]++;
        if (b.last) begin
          m_done[sel] = 1; m_load[sel] = 0;
        end else if (m_cnt[sel] == depth[sel]) begin
          m_ovf[sel] = 1; m_load[sel] = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("imem_we", sel ? 32'(bus_b.imem_we) : 32'(bus_a.imem_we), 32'(wr));
    if (wr) begin
      chk("imem_addr",  sel ? 32'(bus_b.imem_addr) : 32'(bus_a.imem_addr), 32'(exp_addr));
      chk("imem_wdata", sel ? bus_b.imem_wdata : bus_a.imem_wdata, exp_data);
    end
    check_status(sel);
    start_a = 0; start_b = 0; bus_a.in_valid = 0; bus_b.in_valid = 0;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_ready"}, 32'(bus_a.in_ready), 32'd0);
    chk({tag, "_we"},    32'(bus_a.imem_we),  32'd0);
    chk({tag, "_addr"},  32'(bus_a.imem_addr), 32'd0);
    chk({tag, "_wdata"}, bus_a.imem_wdata,     32'd0);
    chk({tag, "_flags"}, {27'd0, busy_a, done_a, ovf_a, ill_a, 1'b0}, 32'd0);
    chk({tag, "_count"}, 32'(count_a), 32'd0);
  endtask

  initial begin
    beat_t nop, b;
    int n, i;
    bit vld;
    nop = mk(3'd0, 0, 0, 0, 0, 0, 0);
    drive(nop);
    bus_a.in_valid = 0; bus_b.in_valid = 0;
    model_reset();
    #2;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    reset = 0;

    // 1: ADD, ADDI, JAL(last)
    step(0, 1, 0, nop);
    step(0, 0, 1, mk(3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 26'd0, 0));
    step(0, 0, 1, mk(3'd1, 5'd0, 5'd4, 5'd0, 6'd0, 26'd5, 0));
    step(0, 0, 1, mk(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 26'h10, 1));
    step(0, 0, 1, mk(3'd1, 5'd1, 5'd1, 5'd0, 6'd0, 26'd1, 0));

    // 2: LW/SW with valid toggling
    step(0, 1, 0, nop);
    step(0, 0, 0, nop);
    step(0, 0, 1, mk(3'd4, 5'd29, 5'd8, 5'd0, 6'd0, 26'h0FFFC, 0));
    step(0, 0, 0, nop);
    step(0, 0, 1, mk(3'd5, 5'd29, 5'd8, 5'd0, 6'd0, 26'd4, 1));
    step(0, 0, 0, nop);

    // 3: overflow on the 4-word instance
    step(1, 1, 0, nop);
    for (int k = 0; k < 5; k++) step(1, 0, 1, rand_beat(0));
    step(1, 0, 0, nop);

    // 4: BEQ then illegal op
    step(0, 1, 0, nop);
    step(0, 0, 1, mk(3'd2, 5'd1, 5'd2, 5'd0, 6'd0, 26'h0FFFF, 0));
    step(0, 0, 1, mk(3'd7, 5'd3, 5'd3, 5'd3, 6'd3, 26'd3, 0));
    step(0, 0, 1, mk(3'd1, 5'd1, 5'd1, 5'd0, 6'd0, 26'd1, 0));

    // 5: start mid-LOAD together with valid
    step(0, 1, 0, nop);
    step(0, 0, 1, rand_beat(0));
    step(0, 0, 1, rand_beat(0));
    step(0, 1, 1, rand_beat(0));
    step(0, 0, 1, rand_beat(0));
    step(0, 0, 1, rand_beat(1));

    // randomized sessions
    for (int r = 0; r < 4; r++) begin
      step(0, 1, 0, nop);
      n = $urandom_range(3, 12);
      i = 0;
      while (i < n) begin
        vld = 1'($urandom_range(0, 1));
        b = rand_beat(i == n - 1);
        step(0, 0, vld, b);
        if (vld) i++;
      end
      step(0, 0, 1, rand_beat(0));
    end

    // 6: asynchronous reset between edges with a beat pending
    step(0, 1, 0, nop);
    step(0, 0, 1, rand_beat(0));
    @(negedge clk);
    drive(rand_beat(0));
    bus_a.in_valid = 1;
    #2;
    reset = 1;
    model_reset();
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    chk("async_reset_no_write", 32'(bus_a.imem_we), 32'd0);
    check_status(0);
    bus_a.in_valid = 0;
    @(negedge clk);
    reset = 0;
    step(0, 0, 1, rand_beat(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
